snoop_bus_controller: RTL and testbench

- Shared snooping-bus stage sitting downstream of the per-processor MESI emitter FSMs and upstream of their receiver FSMs.
- Arbitrates bus requests from NPROC processors round-robin and broadcasts the winning miss/invalidate message to all caches.
- Collects snoop responses (shared hit, write-back), performs the memory write-back/read, and returns a data-reply message (code 3'b101) to the requester.

---
 rtl/mesi_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/snoop_bus_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_snoop_bus_controller.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesi_pkg.sv
// Shared definitions for the snooping-bus stage: bus command codes, MESI line states,
// message layout and the bus controller FSM states.
package mesi_pkg;

  // Bus request commands
  localparam logic [1:0] READ_MISS   = 2'b00;
  localparam logic [1:0] WRITE_MISS  = 2'b01;
  localparam logic [1:0] INVALIDATE  = 2'b10;
  localparam logic [1:0] ILLEGAL_CMD = 2'b11;

  // MESI line states held by the caches
  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_S = 2'b01;
  localparam logic [1:0] MESI_E = 2'b10;
  localparam logic [1:0] MESI_M = 2'b11;

  // Message layout, MSB first: {shared, code[2:0], tag, data}
  localparam int unsigned CODE_W    = 3;
  localparam int unsigned MSG_HDR_W = 1 + CODE_W;
  localparam logic [CODE_W-1:0] MSG_RETURN = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StBcast,
    StSnoop,
    StWb,
    StMemrd,
    StReply
  } bus_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping, and
// moves the pointer to one past the winner when the grant is taken.
module rr_arbiter #(
  parameter int unsigned NPROC = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NPROC-1:0] req_i,
  input  logic             adv_i,
  output logic [NPROC-1:0] grant_o,
  output logic             any_o
);

  localparam int unsigned PtrW = (NPROC > 1) ? $clog2(NPROC) : 1;

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] win_idx;
  logic            found;
  int unsigned     idx;

  // Rotating priority search starting at the pointer
  always_comb begin
    grant_o = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < NPROC; i++) begin
      idx = (32'(ptr_q) + i) % NPROC;
      if (!found && req_i[idx[PtrW-1:0]]) begin
        found                   = 1'b1;
        win_idx                 = idx[PtrW-1:0];
        grant_o[idx[PtrW-1:0]]  = 1'b1;
      end
    end
    any_o = found;
  end

  // Pointer moves only when the controller accepts a grant
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && found) begin
      ptr_d = (32'(win_idx) == NPROC - 1) ? '0 : win_idx + PtrW'(1);
    end
  end

  // Pointer register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/snoop_bus_controller.sv
// Snooping-bus controller: arbitrates processor requests, broadcasts the winning message,
// collects snoop responses, performs the memory write-back or read and returns a data reply.
module snoop_bus_controller
  import mesi_pkg::*;
#(
  parameter int unsigned NPROC  = 4,
  parameter int unsigned TAG_W  = 1,
  parameter int unsigned DATA_W = 3,
  parameter int unsigned MSG_W  = MSG_HDR_W + TAG_W + DATA_W
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [NPROC-1:0]        req_valid,
  input  logic [2*NPROC-1:0]      req_cmd,
  input  logic [TAG_W*NPROC-1:0]  req_tag,
  output logic [NPROC-1:0]        req_grant,
  output logic                    bus_valid,
  output logic [MSG_W-1:0]        bus_msg,
  output logic [NPROC-1:0]        bus_src,
  input  logic [NPROC-1:0]        snoop_hit,
  input  logic [NPROC-1:0]        snoop_wb,
  input  logic [DATA_W*NPROC-1:0] snoop_wb_data,
  output logic                    mem_wr_en,
  output logic                    mem_rd_en,
  output logic [TAG_W-1:0]        mem_tag,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    reply_valid,
  output logic [NPROC-1:0]        reply_dst,
  output logic [MSG_W-1:0]        reply_msg,
  output logic                    proto_err
);

  bus_state_e        state_q, state_d;
  logic [NPROC-1:0]  src_q, src_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [NPROC-1:0]  wb_q, wb_d;
  logic              shared_q, shared_d;
  logic              rd_wait_q, rd_wait_d;
  logic              proto_err_q, proto_err_d;

  logic [NPROC-1:0]  arb_grant;
  logic              arb_any;
  logic              arb_adv;
  logic [1:0]        win_cmd;
  logic [TAG_W-1:0]  win_tag;
  logic [NPROC-1:0]  hit_m, wb_m;
  logic [DATA_W-1:0] wb_sel_data;
  logic              reply_shared;

  assign arb_adv = (state_q == StIdle) && arb_any;

  rr_arbiter #(
    .NPROC (NPROC)
  ) u_rr_arbiter (
    .clk_i   (clock),
    .rst_ni  (resetn),
    .req_i   (req_valid),
    .adv_i   (arb_adv),
    .grant_o (arb_grant),
    .any_o   (arb_any)
  );

  // Select the winner's command and tag
  always_comb begin
    win_cmd = '0;
    win_tag = '0;
    for (int i = 0; i < int'(NPROC); i++) begin
      if (arb_grant[i]) begin
        win_cmd = req_cmd[2*i +: 2];
        win_tag = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  // Snoop responses with the requester's own bit masked; lowest-index write-back wins
  always_comb begin
    hit_m       = snoop_hit & ~src_q;
    wb_m        = snoop_wb & ~src_q;
    wb_sel_data = '0;
    for (int i = int'(NPROC) - 1; i >= 0; i--) begin
      if (wb_m[i]) wb_sel_data = snoop_wb_data[DATA_W*i +: DATA_W];
    end
  end

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Transaction context registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      src_q       <= '0;
      cmd_q       <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      wb_q        <= '0;
      shared_q    <= 1'b0;
      rd_wait_q   <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      src_q       <= src_d;
      cmd_q       <= cmd_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      wb_q        <= wb_d;
      shared_q    <= shared_d;
      rd_wait_q   <= rd_wait_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Next-state and context updates
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    cmd_d       = cmd_q;
    tag_d       = tag_q;
    data_d      = data_q;
    wb_d        = wb_q;
    shared_d    = shared_q;
    rd_wait_d   = rd_wait_q;
    proto_err_d = proto_err_q;
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          src_d     = arb_grant;
          cmd_d     = win_cmd;
          tag_d     = win_tag;
          data_d    = '0;
          wb_d      = '0;
          shared_d  = 1'b0;
          rd_wait_d = 1'b0;
          // Illegal command is granted to unblock the requester but never broadcast
          if (win_cmd == ILLEGAL_CMD) proto_err_d = 1'b1;
          else                        state_d     = StBcast;
        end
      end
      StBcast: state_d = StSnoop;
      StSnoop: begin
        shared_d = |hit_m;
        wb_d     = wb_m;
        if (cmd_q == INVALIDATE) begin
          state_d = StIdle;
        end else if (|wb_m) begin
          data_d  = wb_sel_data;
          state_d = StWb;
        end else begin
          state_d = StMemrd;
        end
      end
      StWb: begin
        if (|(wb_q & (wb_q - NPROC'(1)))) proto_err_d = 1'b1;
        state_d = StReply;
      end
      StMemrd: begin
        // First cycle strobes the read, second captures the returned data
        if (!rd_wait_q) begin
          rd_wait_d = 1'b1;
        end else begin
          rd_wait_d = 1'b0;
          data_d    = mem_rdata;
          state_d   = StReply;
        end
      end
      StReply: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Other caches invalidate on a write miss, so the requester never sees it shared
  assign reply_shared = (cmd_q == WRITE_MISS) ? 1'b0 : shared_q;

  // Moore outputs decoded from the state; grant is gated so reset forces it low
  always_comb begin
    req_grant   = '0;
    bus_valid   = 1'b0;
    bus_msg     = '0;
    bus_src     = '0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_tag     = '0;
    mem_wdata   = '0;
    reply_valid = 1'b0;
    reply_dst   = '0;
    reply_msg   = '0;
    unique case (state_q)
      StIdle: begin
        if (resetn) req_grant = arb_grant;
      end
      StBcast: begin
        bus_valid = 1'b1;
        bus_msg   = {1'b0, 1'b0, cmd_q, tag_q, {DATA_W{1'b0}}};
        bus_src   = src_q;
      end
      StWb: begin
        mem_wr_en = 1'b1;
        mem_tag   = tag_q;
        mem_wdata = data_q;
      end
      StMemrd: begin
        mem_rd_en = !rd_wait_q;
        mem_tag   = rd_wait_q ? '0 : tag_q;
      end
      StReply: begin
        reply_valid = 1'b1;
        reply_dst   = src_q;
        reply_msg   = {reply_shared, MSG_RETURN, tag_q, data_q};
      end
      default: ;
    endcase
  end

  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_snoop_bus_controller.sv
// Directed, table-driven bench for snoop_bus_controller plus hand-written reset,
// round-robin fairness and illegal-command sequences.
module tb_snoop_bus_controller;

  logic        clock;
  logic        resetn;
  logic [3:0]  req_valid;
  logic [7:0]  req_cmd;
  logic [3:0]  req_tag;
  logic [3:0]  req_grant;
  logic        bus_valid;
  logic [7:0]  bus_msg;
  logic [3:0]  bus_src;
  logic [3:0]  snoop_hit;
  logic [3:0]  snoop_wb;
  logic [11:0] snoop_wb_data;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [0:0]  mem_tag;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata;
  logic        reply_valid;
  logic [3:0]  reply_dst;
  logic [7:0]  reply_msg;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  snoop_bus_controller u_dut (
    .clock         (clock),
    .resetn        (resetn),
    .req_valid     (req_valid),
    .req_cmd       (req_cmd),
    .req_tag       (req_tag),
    .req_grant     (req_grant),
    .bus_valid     (bus_valid),
    .bus_msg       (bus_msg),
    .bus_src       (bus_src),
    .snoop_hit     (snoop_hit),
    .snoop_wb      (snoop_wb),
    .snoop_wb_data (snoop_wb_data),
    .mem_wr_en     (mem_wr_en),
    .mem_rd_en     (mem_rd_en),
    .mem_tag       (mem_tag),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .reply_valid   (reply_valid),
    .reply_dst     (reply_dst),
    .reply_msg     (reply_msg),
    .proto_err     (proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packed view of every output: {grant, bv, msg, src, wr, rd, mtag, wdata, rv, dst, rmsg, err}
  logic [36:0] obs;
  assign obs = {req_grant, bus_valid, bus_msg, bus_src, mem_wr_en, mem_rd_en, mem_tag,
                mem_wdata, reply_valid, reply_dst, reply_msg, proto_err};

  typedef struct {
    logic [3:0]  rv;
    logic [7:0]  cmd;
    logic [3:0]  tag;
    logic [3:0]  hit;
    logic [3:0]  wb;
    logic [11:0] wbd;
    logic [2:0]  rd;
    logic [36:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [3:0] rv, input logic [7:0] cmd, input logic [3:0] tag,
                              input logic [3:0] hit, input logic [3:0] wb, input logic [11:0] wbd,
                              input logic [2:0] rd, input logic [3:0] g, input logic bv,
                              input logic [7:0] msg, input logic [3:0] src, input logic wr,
                              input logic rdn, input logic mt, input logic [2:0] wd,
                              input logic rvl, input logic [3:0] dst, input logic [7:0] rm,
                              input logic err);
    vec_t v;
    v.rv  = rv;
    v.cmd = cmd;
    v.tag = tag;
    v.hit = hit;
    v.wb  = wb;
    v.wbd = wbd;
    v.rd  = rd;
    v.exp = {g, bv, msg, src, wr, rdn, mt, wd, rvl, dst, rm, err};
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    req_valid     = '0;
    req_cmd       = '0;
    req_tag       = '0;
    snoop_hit     = '0;
    snoop_wb      = '0;
    snoop_wb_data = '0;
    mem_rdata     = '0;
  endtask

  logic [3:0] rr_exp [5];
  int         k;
  int         cyc;
  int         nrep;
  logic       rep_seen;
  logic [3:0] rep_dst;

  initial begin
    resetn = 1'b0;
    drive_idle();

    // P1 read miss tag 1, no hits, memory returns 110
    vq.push_back(mk(4'b0010, '0, 4'b0010, '0, '0, '0, '0,  4'b0010, 0, '0, '0, 0, 0, 0, '0, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, '0, '0, '0, '0,  '0, 1, 8'b0000_1000, 4'b0010, 0, 0, 0, '0, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, '0, '0, '0, '0,  '0, 0, '0, '0, 0, 0, 0, '0, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, '0, '0, '0, '0,  '0, 0, '0, '0, 0, 1, 1, '0, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, '0, '0, '0, 3'b110,  '0, 0, '0, '0, 0, 0, 0, '0, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, '0, '0, '0, '0,  '0, 0, '0, '0, 0, 0, 0, '0, 1, 4'b0010, 8'b0101_1110, 0));
    vq.push_back(mk('0, '0, '0, '0, '0, '0, '0,  '0, 0, '0, '0, 0, 0, 0, '0, 0, '0, '0, 0));
    // P0 read miss tag 0, P2 hit with write-back data 011
    vq.push_back(mk(4'b0001, '0, '0, '0, '0, '0, '0,  4'b0001, 0, '0, '0, 0, 0, 0, '0, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, '0, '0, '0, '0,  '0, 1, 8'b0000_0000, 4'b0001, 0, 0, 0, '0, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, 4'b0100, 4'b0100, 12'b000_011_000_000, '0,
                    '0, 0, '0, '0, 0, 0, 0, '0, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, 4'b0100, 4'b0100, 12'b000_011_000_000, '0,
                    '0, 0, '0, '0, 1, 0, 0, 3'b011, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, '0, '0, '0, '0,  '0, 0, '0, '0, 0, 0, 0, '0, 1, 4'b0001, 8'b1101_0011, 0));
    vq.push_back(mk('0, '0, '0, '0, '0, '0, '0,  '0, 0, '0, '0, 0, 0, 0, '0, 0, '0, '0, 0));
    // P3 invalidate tag 1, P0/P1 hit: no memory, no reply, idle again at +3
    vq.push_back(mk(4'b1000, 8'b10_00_00_00, 4'b1000, '0, '0, '0, '0,
                    4'b1000, 0, '0, '0, 0, 0, 0, '0, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, '0, '0, '0, '0,  '0, 1, 8'b0010_1000, 4'b1000, 0, 0, 0, '0, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, 4'b0011, '0, '0, '0,  '0, 0, '0, '0, 0, 0, 0, '0, 0, '0, '0, 0));
    // P2 write miss tag 1, P0 and P1 both write back (P0=101, P1=010)
    vq.push_back(mk(4'b0100, 8'b00_01_00_00, 4'b0100, '0, '0, '0, '0,
                    4'b0100, 0, '0, '0, 0, 0, 0, '0, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, '0, '0, '0, '0,  '0, 1, 8'b0001_1000, 4'b0100, 0, 0, 0, '0, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, 4'b0011, 4'b0011, 12'b000_000_010_101, '0,
                    '0, 0, '0, '0, 0, 0, 0, '0, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, 4'b0011, 4'b0011, 12'b000_000_010_101, '0,
                    '0, 0, '0, '0, 1, 0, 1, 3'b101, 0, '0, '0, 0));
    vq.push_back(mk('0, '0, '0, '0, '0, '0, '0,  '0, 0, '0, '0, 0, 0, 0, '0, 1, 4'b0100, 8'b0101_1101, 1));
    vq.push_back(mk('0, '0, '0, '0, '0, '0, '0,  '0, 0, '0, '0, 0, 0, 0, '0, 0, '0, '0, 1));

    // Reset state with nothing requesting
    tick();
    tick();
    check("reset_outputs", 64'(obs), 64'(0));
    #1 resetn = 1'b1;
    tick();

    for (int i = 0; i < vq.size(); i++) begin
      req_valid     = vq[i].rv;
      req_cmd       = vq[i].cmd;
      req_tag       = vq[i].tag;
      snoop_hit     = vq[i].hit;
      snoop_wb      = vq[i].wb;
      snoop_wb_data = vq[i].wbd;
      mem_rdata     = vq[i].rd;
      #1;
      check($sformatf("vec%0d", i), 64'(obs), 64'(vq[i].exp));
      tick();
    end

    // Reset in the middle of a memory read drops the transaction
    drive_idle();
    req_valid = 4'b0100;
    #1;
    check("rst_seq_grant", 64'(req_grant), 64'(4'b0100));
    tick();
    req_valid = '0;
    tick();
    tick();
    #1;
    check("rst_seq_memrd", 64'(mem_rd_en), 64'(1));
    resetn = 1'b0;
    #1;
    check("rst_async_outputs", 64'(obs), 64'(0));
    tick();
    @(negedge clock);
    resetn = 1'b1;
    nrep = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (reply_valid) nrep++;
    end
    check("rst_no_reply", 64'(nrep), 64'(0));

    // All four requesting: grants rotate from pointer 0, each reply before the next grant
    rr_exp[0] = 4'b0001;
    rr_exp[1] = 4'b0010;
    rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000;
    rr_exp[4] = 4'b0001;
    req_valid = 4'b1111;
    mem_rdata = 3'b001;
    k         = 0;
    cyc       = 0;
    rep_seen  = 1'b0;
    rep_dst   = '0;
    #1;
    while (k < 5 && cyc < 80) begin
      if (reply_valid) begin
        rep_seen = 1'b1;
        rep_dst  = reply_dst;
      end
      if (req_grant != '0) begin
        check($sformatf("rr_grant%0d", k), 64'(req_grant), 64'(rr_exp[k]));
        if (k > 0) begin
          check($sformatf("rr_reply_before%0d", k), 64'({rep_seen, rep_dst}),
                64'({1'b1, rr_exp[k-1]}));
        end
        rep_seen = 1'b0;
        k++;
      end
      if (k < 5) begin
        tick();
        cyc++;
      end
    end
    check("rr_all_grants_seen", 64'(k), 64'(5));
    tick();
    req_valid = '0;
    cyc       = 0;
    while (!reply_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("rr_last_reply_dst", 64'(reply_dst), 64'(4'b0001));
    tick();

    // Illegal command: grant pulsed, flag set, no broadcast, idle on the next cycle
    drive_idle();
    req_valid = 4'b0010;
    req_cmd   = 8'b00_00_11_00;
    #1;
    check("ill_grant", 64'({req_grant, proto_err}), 64'({4'b0010, 1'b0}));
    tick();
    req_cmd   = '0;
    req_valid = 4'b1000;
    #1;
    check("ill_no_bcast", 64'({bus_valid, proto_err}), 64'({1'b0, 1'b1}));
    check("ill_back_idle", 64'(req_grant), 64'(4'b1000));
    tick();
    req_valid = '0;
    #1;
    check("ill_next_bcast", 64'({bus_valid, bus_msg, bus_src}),
          64'({1'b1, 8'b0000_0000, 4'b1000}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
